// File: rtl/majority_voter_nch.sv
// rtl/majority_voter_nch.sv - registered N-channel bitwise majority voter with fault masking
module majority_voter_nch #(
    parameter int N_CH        = 3,
    parameter int WIDTH       = 4,
    parameter int FAULT_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic                    clear_faults,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_tie,
    output logic                    out_no_quorum,
    output logic [N_CH-1:0]         ch_mask,
    output logic                    fault_irq
);

    localparam int CW = $clog2(N_CH + 1);
    localparam int FW = $clog2(FAULT_LIMIT + 1);
    localparam logic [FW-1:0] FLIM = FW'(FAULT_LIMIT);

    logic                     out_valid_q;
    logic [WIDTH-1:0]         out_data_q;
    logic                     out_tie_q;
    logic                     out_no_quorum_q;
    logic [N_CH-1:0]          mask_q, mask_d;
    logic                     fault_irq_q, fault_irq_d;
    logic [N_CH-1:0][FW-1:0]  cnt_q, cnt_d;

    logic [CW-1:0]            en_cnt;
    logic [CW-1:0]            ones;
    logic [CW:0]              twice;
    logic [WIDTH-1:0]         vote_word;
    logic                     vote_tie;
    logic                     vote_no_quorum;

    // Vote over the channels enabled at this edge; a tie resolves to 0.
    always_comb begin
        en_cnt    = '0;
        ones      = '0;
        twice     = '0;
        vote_word = '0;
        vote_tie  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            en_cnt = en_cnt + CW'(!mask_q[i]);
        end
        for (int b = 0; b < WIDTH; b++) begin
            ones = '0;
            for (int i = 0; i < N_CH; i++) begin
                if (!mask_q[i] && in_data[i*WIDTH + b]) begin
                    ones = ones + CW'(1);
                end
            end
            twice = {ones, 1'b0};
            if (twice > {1'b0, en_cnt}) begin
                vote_word[b] = 1'b1;
            end else if ((twice == {1'b0, en_cnt}) && (en_cnt != '0)) begin
                vote_tie = 1'b1;
            end
        end
        vote_no_quorum = (en_cnt == '0);
    end

    always_comb begin
        cnt_d  = cnt_q;
        mask_d = mask_q;
        if (clear_faults) begin
            cnt_d  = '0;
            mask_d = '0;
        end else if (in_valid) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!mask_q[i]) begin
                    if (in_data[i*WIDTH +: WIDTH] != vote_word) begin
                        if (cnt_q[i] != FLIM) begin
                            cnt_d[i] = cnt_q[i] + FW'(1);
                        end
                        if (cnt_d[i] == FLIM) begin
                            mask_d[i] = 1'b1;
                        end
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
            end
        end
        fault_irq_d = |(mask_d & ~mask_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_tie_q       <= 1'b0;
            out_no_quorum_q <= 1'b0;
            mask_q          <= '0;
            cnt_q           <= '0;
            fault_irq_q     <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_data_q      <= vote_word;
                out_tie_q       <= vote_tie;
                out_no_quorum_q <= vote_no_quorum;
            end
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            fault_irq_q <= fault_irq_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_tie       = out_tie_q;
    assign out_no_quorum = out_no_quorum_q;
    assign ch_mask       = mask_q;
    assign fault_irq     = fault_irq_q;

endmodule

// File: tb/tb_majority_voter_nch.sv
// tb/tb_majority_voter_nch.sv - scoreboard bench for majority_voter_nch
module tb_majority_voter_nch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] in_data = '0;
    logic        clear_faults = 1'b0;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        out_tie;
    logic        out_no_quorum;
    logic [2:0]  ch_mask;
    logic        fault_irq;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    majority_voter_nch #(.N_CH(3), .WIDTH(4), .FAULT_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .clear_faults(clear_faults), .out_valid(out_valid), .out_data(out_data),
        .out_tie(out_tie), .out_no_quorum(out_no_quorum), .ch_mask(ch_mask),
        .fault_irq(fault_irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one valid vote; expected {data, tie, no_quorum} queued at the sampling edge.
    task automatic vote(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                        input logic [3:0] ed, input logic et, input logic enq, input logic clr);
        in_valid     = 1'b1;
        in_data      = {c2, c1, c0};
        clear_faults = clr;
        @(posedge clk);
        exp_q.push_back({ed, et, enq});
        #1;
        in_valid     = 1'b0;
        clear_faults = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e[5:2]));
                chk("out_tie", 32'(out_tie), 32'(e[1]));
                chk("out_no_quorum", 32'(out_no_quorum), 32'(e[0]));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_tie", 32'(out_tie), 32'd0);
        chk("rst_no_quorum", 32'(out_no_quorum), 32'd0);
        chk("rst_ch_mask", 32'(ch_mask), 32'd0);
        chk("rst_fault_irq", 32'(fault_irq), 32'd0);

        vote(4'hA, 4'hA, 4'hA, 4'hA, 1'b0, 1'b0, 1'b0);
        chk("s2_irq", 32'(fault_irq), 32'd0);
        vote(4'hF, 4'h3, 4'h5, 4'h7, 1'b0, 1'b0, 1'b0);
        vote(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        vote(4'h9, 4'h9, 4'h0, 4'h9, 1'b0, 1'b0, 1'b0);
        vote(4'h9, 4'h9, 4'h0, 4'h9, 1'b0, 1'b0, 1'b0);
        chk("s4_mask_before", 32'(ch_mask), 32'd0);
        chk("s4_irq_before", 32'(fault_irq), 32'd0);
        vote(4'h9, 4'h9, 4'h0, 4'h9, 1'b0, 1'b0, 1'b0);
        chk("s4_mask", 32'(ch_mask), 32'b100);
        chk("s4_irq", 32'(fault_irq), 32'd1);
        vote(4'h1, 4'h2, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("s4_irq_pulse_end", 32'(fault_irq), 32'd0);
        chk("s4_mask_hold", 32'(ch_mask), 32'b100);

        vote(4'h6, 4'h6, 4'h0, 4'h6, 1'b0, 1'b0, 1'b1);
        chk("s5_mask_clr", 32'(ch_mask), 32'd0);
        chk("s5_irq", 32'(fault_irq), 32'd0);
        vote(4'h6, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("s5_mask_after", 32'(ch_mask), 32'd0);

        vote(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        vote(4'h1, 4'h2, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0);
        vote(4'h1, 4'h2, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("s6_mask_before", 32'(ch_mask), 32'd0);
        vote(4'h1, 4'h2, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("s6_mask_all", 32'(ch_mask), 32'b111);
        chk("s6_irq", 32'(fault_irq), 32'd1);
        vote(4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("s6_irq_end", 32'(fault_irq), 32'd0);

        @(posedge clk);
        #2;
        in_valid = 1'b1;
        in_data  = {4'h3, 4'h3, 4'h3};
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_ch_mask", 32'(ch_mask), 32'd0);
        chk("async_rst_no_quorum", 32'(out_no_quorum), 32'd0);
        exp_q.delete();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        vote(4'h5, 4'h5, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0);
        chk("post_rst_mask", 32'(ch_mask), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/majority_voter_nch.md
Name: majority_voter_nch

Overview:
- Parametrised, registered N-channel, W-bit bitwise majority voter; successor to the 3-input single-bit combinational voter.
- Adds per-channel disagreement tracking, automatic masking of persistently faulty channels, tie and no-quorum detection, and a valid-qualified registered output.
- Sits between redundant producer channels (replicated datapaths/sensors) and a single consumer.

Parameters:
- N_CH, 3, number of input channels; range 1..16.
- WIDTH, 4, bits per channel word; must be at least 1.
- FAULT_LIMIT, 3, consecutive mismatching valid votes before a channel is masked; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  qualifies in_data for one vote this cycle.
- in_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- clear_faults  in  1  clears all mismatch counters and the channel mask.
- out_valid  out  1  out_data/flags valid; registered.
- out_data  out  WIDTH  voted word; registered.
- out_tie  out  1  at least one bit tied in the vote; registered.
- out_no_quorum  out  1  vote taken with zero enabled channels; registered.
- ch_mask  out  N_CH  bit i = 1: channel i excluded from voting.
- fault_irq  out  1  one-cycle pulse when any channel becomes masked.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid, out_data, out_tie, out_no_quorum, ch_mask, fault_irq, and all mismatch counters = 0 immediately. Reset has priority over everything.
- Enabled set: channels with ch_mask bit = 0 at the current edge. E = count of enabled channels.
- Per-bit vote: ones = number of enabled channels with bit = 1.
  - Result bit = 1 iff 2*ones > E.
  - Tie (2*ones == E, E > 0): result bit = 0 and the cycle's tie flag is set.
  - Counts are sized to hold N_CH without overflow.
- E == 0: voted word = 0, out_tie = 0, out_no_quorum = 1.
- Latency: the vote is combinational from the current in_data and ch_mask. It is registered on the edge where in_valid = 1, so outputs appear 1 cycle after in_valid.
- out_valid = registered in_valid. When in_valid = 0, out_data, out_tie and out_no_quorum hold their previous values.
- Mismatch tracking (only on in_valid = 1, only for enabled channels):
  - Channel word != voted word: the counter increments, saturating at FAULT_LIMIT.
  - Channel word == voted word: the counter resets to 0.
  - Masked channels' counters hold.
- Masking:
  - When an enabled channel's counter reaches FAULT_LIMIT on an edge, its ch_mask bit is set on that same edge; it is excluded from votes from the next cycle on.
  - fault_irq = 1 for exactly the cycle after any mask bit transitions 0 to 1. Several channels masked together produce a single pulse.
  - A channel may be masked even if that leaves E = 0.
- clear_faults = 1 at an edge:
  - ch_mask and all counters are set to 0.
  - This takes priority over mismatch updates and new masking at that same edge; fault_irq does not pulse.
  - The vote registered at that edge still uses the pre-clear mask.
- Reset mid-operation: any in-flight vote is discarded and out_valid drops to 0 asynchronously. The first valid vote after reset release uses all channels.

Test Plan (N_CH=3, WIDTH=4, FAULT_LIMIT=3):
1. Reset asserted then released, no stimulus -> all outputs 0, ch_mask=3'b000.
2. in_valid=1 with ch0=ch1=ch2=0xA -> next cycle out_valid=1, out_data=0xA, out_tie=0, fault_irq=0.
3. ch0=0xF, ch1=0x3, ch2=0x5 for one valid cycle -> out_data=0x7. All three counters become 1 (each differs from 0x7).
4. Three consecutive valid votes with ch0=ch1=0x9, ch2=0x0 -> ch_mask=3'b100 after the third edge, fault_irq pulses one cycle. Then ch0=0x1, ch1=0x2 (ch2 ignored) -> out_data=0x0, out_tie=1.
5. Starting from the state of scenario 4, clear_faults=1 with in_valid=1 and ch2 still mismatching -> ch_mask=3'b000, counters 0, no fault_irq. The next vote uses all 3 channels.
6. Mask all three channels, then vote -> out_data=0x0, out_no_quorum=1. Assert rst_n=0 mid-stream with in_valid=1 -> out_valid=0 and ch_mask=0 immediately, without waiting for a clock edge.
